// File: rtl/axil_txn_sequencer.sv
// rtl/axil_txn_sequencer.sv - AXI4-Lite write/readback self-test sequencer
// One run per synchronized start edge; pass holds the verdict of the last completed run.
module axil_txn_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] TEST_ADDR = 32'h0000_0004,
  parameter logic [DATA_W-1:0] TEST_SEED = 32'hA5A5_0000,
  parameter int                TIMEOUT   = 255
) (
  input  logic                sysclk,
  input  logic                aresetn,
  input  logic                start,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic                busy,
  output logic                done,
  output logic                pass
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_BRESP, S_READ, S_RDATA, S_DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t              r_state;
  logic                r_sync1, r_sync2, r_sync3;
  logic [15:0]         r_cnt;
  logic [15:0]         r_run_cnt;
  logic                r_aw_done, r_w_done;
  logic [1:0]          r_bresp;
  logic [ADDR_W-1:0]   r_awaddr, r_araddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                r_busy, r_done, r_pass;

  logic w_start_rise, w_tmo, w_aw_hs, w_w_hs;

  assign w_start_rise = r_sync2 & ~r_sync3;
  assign w_tmo        = (r_cnt == TO_LAST);
  assign w_aw_hs      = r_awvalid & m_axi_awready;
  assign w_w_hs       = r_wvalid & m_axi_wready;

  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;

  always_ff @(posedge sysclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_cnt     <= '0;
      r_run_cnt <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_bresp   <= 2'b00;
      r_awaddr  <= '0;
      r_araddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
    end else begin
      r_sync1 <= start;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_cnt   <= r_cnt + 16'd1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_start_rise) begin
            r_state   <= S_WRITE;
            r_busy    <= 1'b1;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= TEST_ADDR;
            r_araddr  <= TEST_ADDR;
            r_wdata   <= TEST_SEED + DATA_W'(r_run_cnt);
          end
        end
        S_WRITE: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Address and data channels may complete in either order or together.
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_state  <= S_BRESP;
            r_bready <= 1'b1;
            r_cnt    <= '0;
          end else if (w_tmo) begin
            r_state   <= S_DONE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_BRESP: begin
          if (m_axi_bvalid) begin
            r_bresp   <= m_axi_bresp;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b1;
            r_state   <= S_READ;
            r_cnt     <= '0;
          end else if (w_tmo) begin
            r_bready <= 1'b0;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_pass   <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_READ: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RDATA;
            r_cnt     <= '0;
          end else if (w_tmo) begin
            r_arvalid <= 1'b0;
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_RDATA: begin
          if (m_axi_rvalid) begin
            r_rready <= 1'b0;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_pass   <= (r_bresp == 2'b00) && (m_axi_rresp == 2'b00) &&
                        (m_axi_rdata == r_wdata);
            r_cnt    <= '0;
          end else if (w_tmo) begin
            r_rready <= 1'b0;
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_pass   <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_DONE: begin
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_run_cnt <= r_run_cnt + 16'd1;
          r_state   <= S_IDLE;
          r_cnt     <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_txn_sequencer.sv
// tb/tb_axil_txn_sequencer.sv - self-checking bench for axil_txn_sequencer
// Configurable AXI-Lite slave, per-cycle model checker and directed scenarios.
module tb_axil_txn_sequencer;

  localparam logic [31:0] T_ADDR = 32'h0000_0004;
  localparam logic [31:0] SEED   = 32'hA5A5_0000;

  logic        sysclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, busy, done, pass;
  logic [1:0]  bresp, rresp;

  axil_txn_sequencer #(.TIMEOUT(10)) dut (
    .sysclk(sysclk), .aresetn(aresetn), .start(start),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .busy(busy), .done(done), .pass(pass)
  );

  always #5 sysclk = ~sysclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave configuration and state
  int          cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
  bit          cfg_r_never, cfg_force;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata, mem;

  task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r);
    cfg_aw_dly = aw; cfg_w_dly = w; cfg_b_dly = b; cfg_ar_dly = ar; cfg_r_dly = r;
    cfg_r_never = 0; cfg_force = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
  endtask

  initial begin
    int c_aw, c_w, c_b, c_ar, c_r;
    c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(posedge sysclk);
      #1;
      if (!aresetn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
      end else begin
        if (awvalid) begin awready = (c_aw >= cfg_aw_dly); c_aw++; end
        else begin awready = 0; c_aw = 0; end
        if (wvalid) begin
          wready = (c_w >= cfg_w_dly);
          if (wready) mem = wdata;
          c_w++;
        end else begin wready = 0; c_w = 0; end
        if (bready) begin bvalid = (c_b >= cfg_b_dly); bresp = cfg_bresp; c_b++; end
        else begin bvalid = 0; c_b = 0; end
        if (arvalid) begin arready = (c_ar >= cfg_ar_dly); c_ar++; end
        else begin arready = 0; c_ar = 0; end
        if (rready && !cfg_r_never) begin
          rvalid = (c_r >= cfg_r_dly);
          rdata  = cfg_force ? cfg_rdata : mem;
          rresp  = cfg_rresp;
          c_r++;
        end else begin rvalid = 0; c_r = 0; end
      end
    end
  end

  // Model: run counter, observed responses, expected verdict; plus protocol rules
  logic [15:0] m_run;
  logic        m_pass, got_b, got_r;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  int          n_done = 0;
  int          cyc_busy, cyc_aw, cyc_w, cyc_rr;
  logic        p_aw_wait, p_w_wait, p_ar_wait, p_done;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  task automatic clr_counts();
    cyc_busy = 0; cyc_aw = 0; cyc_w = 0; cyc_rr = 0;
  endtask

  initial begin
    m_run = 0; m_pass = 0; got_b = 0; got_r = 0;
    p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0; p_done = 0;
    forever begin
      @(negedge sysclk);
      if (!aresetn) begin
        m_run = 0; m_pass = 0; got_b = 0; got_r = 0;
        p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0; p_done = 0;
        chk("rst_ctrl", {24'd0, awvalid, wvalid, bready, arvalid, rready, busy, done, pass}, 0);
        chk("rst_data", awaddr | araddr | wdata, 0);
      end else begin
        if (busy) cyc_busy++;
        if (awvalid) cyc_aw++;
        if (wvalid) cyc_w++;
        if (rready) cyc_rr++;
        if (awvalid) chk("awaddr", awaddr, T_ADDR);
        if (arvalid) chk("araddr", araddr, T_ADDR);
        if (wvalid) begin
          chk("wdata", wdata, SEED + {16'd0, m_run});
          chk("wstrb", {28'd0, wstrb}, 32'hF);
        end
        if (p_aw_wait) begin chk("aw_hold", {31'd0, awvalid}, 1); chk("aw_stable", awaddr, p_awaddr); end
        if (p_w_wait)  begin chk("w_hold", {31'd0, wvalid}, 1);   chk("w_stable", wdata, p_wdata); end
        if (p_ar_wait) begin chk("ar_hold", {31'd0, arvalid}, 1); chk("ar_stable", araddr, p_araddr); end
        if (awvalid | wvalid | bready | arvalid | rready | done) chk("busy_on", {31'd0, busy}, 1);
        if (bvalid && bready) begin got_b = 1; m_bresp = bresp; end
        if (rvalid && rready) begin got_r = 1; m_rresp = rresp; m_rdata = rdata; end
        if (done) begin
          m_pass = got_b && got_r && (m_bresp == 2'b00) && (m_rresp == 2'b00) &&
                   (m_rdata == SEED + {16'd0, m_run});
          chk("pass_at_done", {31'd0, pass}, {31'd0, m_pass});
          chk("done_1cyc", {31'd0, p_done}, 0);
          m_run++; got_b = 0; got_r = 0; n_done++;
        end else begin
          chk("pass_sticky", {31'd0, pass}, {31'd0, m_pass});
        end
        p_aw_wait = awvalid && !awready; p_awaddr = awaddr;
        p_w_wait  = wvalid && !wready;   p_wdata  = wdata;
        p_ar_wait = arvalid && !arready; p_araddr = araddr;
        p_done    = done;
      end
    end
  end

  task automatic start_run();
    start = 0;
    repeat (3) @(negedge sysclk);
    clr_counts();
    start = 1;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge sysclk);
      if (done) begin seen = 1; break; end
    end
    chk({nm, "_done_seen"}, {31'd0, seen}, 1);
  endtask

  initial begin
    int nd;
    bit seen;
    set_cfg(0, 0, 0, 0, 0);
    clr_counts();
    repeat (3) @(negedge sysclk);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_pass", {31'd0, pass}, 0);
    aresetn = 1;
    repeat (2) @(negedge sysclk);
    chk("idle_done", {31'd0, done}, 0);

    // Zero-wait slave
    start_run();
    wait_done("t1");
    chk("t1_pass", {31'd0, pass}, 1);
    repeat (2) @(negedge sysclk);
    chk("t1_wdata", mem, 32'hA5A5_0000);
    chk("t1_busy5", {31'd0, cyc_busy >= 5}, 1);
    chk("t1_pass_hold", {31'd0, pass}, 1);

    // Second run: readback returns 0
    set_cfg(0, 0, 0, 0, 0);
    cfg_force = 1; cfg_rdata = 32'h0;
    start_run();
    wait_done("t2");
    chk("t2_pass", {31'd0, pass}, 0);
    repeat (2) @(negedge sysclk);
    chk("t2_wdata", mem, 32'hA5A5_0001);

    // awready late by 3 cycles, start re-pulsed while busy
    set_cfg(3, 0, 3, 0, 0);
    start_run();
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge sysclk);
      if (busy) begin seen = 1; break; end
    end
    chk("t3_busy_seen", {31'd0, seen}, 1);
    start = 0;
    repeat (3) @(negedge sysclk);
    start = 1;
    wait_done("t3");
    chk("t3_pass", {31'd0, pass}, 1);
    repeat (2) @(negedge sysclk);
    chk("t3_aw_cycles", cyc_aw, 4);
    chk("t3_w_cycles", cyc_w, 1);
    chk("t3_wdata", mem, 32'hA5A5_0002);
    nd = n_done;
    repeat (20) @(negedge sysclk);
    chk("t3_no_queue", n_done, nd);

    // SLVERR write response
    set_cfg(0, 0, 1, 0, 0);
    cfg_bresp = 2'b10;
    start_run();
    wait_done("t4");
    chk("t4_pass", {31'd0, pass}, 0);

    // rvalid never comes: timeout after 10 RDATA cycles
    set_cfg(0, 0, 0, 0, 0);
    cfg_r_never = 1;
    start_run();
    wait_done("t5");
    chk("t5_pass", {31'd0, pass}, 0);
    repeat (2) @(negedge sysclk);
    chk("t5_rdata_cycles", cyc_rr, 10);

    // Reset asserted during READ
    set_cfg(0, 0, 0, 5, 0);
    start_run();
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge sysclk);
      if (arvalid) begin seen = 1; break; end
    end
    chk("t6_read_seen", {31'd0, seen}, 1);
    nd = n_done;
    #2 aresetn = 0;
    #1;
    chk("t6_ctrl_zero", {24'd0, awvalid, wvalid, bready, arvalid, rready, busy, done, pass}, 0);
    chk("t6_data_zero", awaddr | araddr | wdata, 0);
    repeat (3) @(negedge sysclk);
    start = 0;
    #2 aresetn = 1;
    repeat (5) @(negedge sysclk);
    chk("t6_no_done", n_done, nd);
    set_cfg(0, 0, 0, 0, 0);
    start_run();
    wait_done("t6");
    chk("t6_pass", {31'd0, pass}, 1);
    repeat (2) @(negedge sysclk);
    chk("t6_wdata", mem, 32'hA5A5_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
